// File: rtl/uart_cmd_bridge_if.sv
// Byte stream, transmit handshake and req/ack bus seen by the UART command bridge.
// master = the bridge itself, slave = the UART/bus side facing it.
interface uart_cmd_bridge_if;
    logic [7:0]  rx_data;
    logic        rx_data_fresh;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ack;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        busy;
    logic        err_overrun;

    modport master (
        input  rx_data, rx_data_fresh, tx_data_ack, bus_rdata, bus_ack,
        output tx_data, tx_data_valid, bus_req, bus_we, bus_addr, bus_wdata,
               busy, err_overrun
    );

    modport slave (
        output rx_data, rx_data_fresh, tx_data_ack, bus_rdata, bus_ack,
        input  tx_data, tx_data_valid, bus_req, bus_we, bus_addr, bus_wdata,
               busy, err_overrun
    );
endinterface

// File: rtl/uart_cmd_bridge.sv
// Host command responder: parses 'W'/'R' byte commands from the UART receiver,
// runs one 32-bit bus access and streams the response bytes back to the transmitter.
//
// state  | meaning
// IDLE   | waiting for a command byte
// ADDR   | collecting 4 address bytes, MSB first
// DATA   | collecting 4 write-data bytes, MSB first
// BUS    | bus_req held until bus_ack or bus timeout
// SEND   | draining the response buffer one byte per tx handshake
module uart_cmd_bridge #(
    parameter int IDLE_TIMEOUT = 5_000_000,
    parameter int BUS_TIMEOUT  = 1024
) (
    input logic               clk,
    input logic               rst,
    uart_cmd_bridge_if.master bif
);
    localparam int IW = $clog2(IDLE_TIMEOUT);
    localparam int BW = $clog2(BUS_TIMEOUT);
    localparam logic [IW-1:0] IDLE_TC = IW'(IDLE_TIMEOUT - 1);
    localparam logic [BW-1:0] BUS_TC  = BW'(BUS_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_BUS  = 3'd3;
    localparam logic [2:0] S_SEND = 3'd4;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] RSP_K = 8'h4B;
    localparam logic [7:0] RSP_Q = 8'h3F;
    localparam logic [7:0] RSP_E = 8'h45;

    logic [2:0]    state;
    logic [IW-1:0] rx_timer;
    logic [BW-1:0] bus_timer;
    logic [1:0]    byte_cnt;
    logic [31:0]   resp_buf;
    logic [2:0]    resp_cnt;
    logic [7:0]    tx_data_r;
    logic          tx_valid_r;
    logic          bus_req_r;
    logic          bus_we_r;
    logic [31:0]   bus_addr_r;
    logic [31:0]   bus_wdata_r;
    logic          overrun_r;

    logic rx_state;
    logic rx_abort;
    logic start_cmd;

    assign rx_state  = (state == S_ADDR) || (state == S_DATA);
    assign rx_abort  = rx_state && (rx_timer == IDLE_TC);
    // A byte landing on the abort cycle is treated as the first byte of a new command.
    assign start_cmd = bif.rx_data_fresh && ((state == S_IDLE) || rx_abort);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rx_timer    <= '0;
            bus_timer   <= '0;
            byte_cnt    <= '0;
            resp_buf    <= '0;
            resp_cnt    <= '0;
            tx_data_r   <= '0;
            tx_valid_r  <= 1'b0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= '0;
            bus_wdata_r <= '0;
            overrun_r   <= 1'b0;
        end else begin
            if (bif.rx_data_fresh && ((state == S_BUS) || (state == S_SEND)))
                overrun_r <= 1'b1;

            if (start_cmd) begin
                byte_cnt <= '0;
                rx_timer <= '0;
                if ((bif.rx_data == CMD_W) || (bif.rx_data == CMD_R)) begin
                    bus_we_r <= (bif.rx_data == CMD_W);
                    state    <= S_ADDR;
                end else begin
                    resp_buf   <= {RSP_Q, 24'h0};
                    resp_cnt   <= 3'd1;
                    tx_data_r  <= RSP_Q;
                    tx_valid_r <= 1'b1;
                    state      <= S_SEND;
                end
            end else begin
                case (state)
                    S_ADDR, S_DATA: begin
                        if (rx_abort) begin
                            state <= S_IDLE;
                        end else if (bif.rx_data_fresh) begin
                            rx_timer <= '0;
                            byte_cnt <= byte_cnt + 2'd1;
                            if (state == S_ADDR)
                                bus_addr_r <= {bus_addr_r[23:0], bif.rx_data};
                            else
                                bus_wdata_r <= {bus_wdata_r[23:0], bif.rx_data};
                            if (byte_cnt == 2'd3) begin
                                if ((state == S_ADDR) && bus_we_r) begin
                                    state <= S_DATA;
                                end else begin
                                    state     <= S_BUS;
                                    bus_req_r <= 1'b1;
                                    bus_timer <= '0;
                                end
                            end
                        end else begin
                            rx_timer <= rx_timer + IW'(1);
                        end
                    end
                    S_BUS: begin
                        if (bif.bus_ack) begin
                            bus_req_r  <= 1'b0;
                            tx_valid_r <= 1'b1;
                            state      <= S_SEND;
                            if (bus_we_r) begin
                                resp_buf  <= {RSP_K, 24'h0};
                                resp_cnt  <= 3'd1;
                                tx_data_r <= RSP_K;
                            end else begin
                                resp_buf  <= bif.bus_rdata;
                                resp_cnt  <= 3'd4;
                                tx_data_r <= bif.bus_rdata[31:24];
                            end
                        end else if (bus_timer == BUS_TC) begin
                            bus_req_r  <= 1'b0;
                            resp_buf   <= {RSP_E, 24'h0};
                            resp_cnt   <= 3'd1;
                            tx_data_r  <= RSP_E;
                            tx_valid_r <= 1'b1;
                            state      <= S_SEND;
                        end else begin
                            bus_timer <= bus_timer + BW'(1);
                        end
                    end
                    S_SEND: begin
                        if (tx_valid_r) begin
                            if (bif.tx_data_ack) begin
                                tx_valid_r <= 1'b0;
                                resp_buf   <= resp_buf << 8;
                                resp_cnt   <= resp_cnt - 3'd1;
                                if (resp_cnt == 3'd1)
                                    state <= S_IDLE;
                            end
                        end else begin
                            tx_data_r  <= resp_buf[31:24];
                            tx_valid_r <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bif.tx_data       = tx_data_r;
    assign bif.tx_data_valid = tx_valid_r;
    assign bif.bus_req       = bus_req_r;
    assign bif.bus_we        = bus_we_r;
    assign bif.bus_addr      = bus_addr_r;
    assign bif.bus_wdata     = bus_wdata_r;
    assign bif.busy          = (state != S_IDLE);
    assign bif.err_overrun   = overrun_r;
endmodule
